// File: rtl/mem_dump_engine.sv
// Hex/ASCII memory dumper: walks a byte range through a shared read port and
// streams a formatted text dump, one character per ready/valid handshake.
module mem_dump_engine #(
    parameter int unsigned ASZ  = 17,
    parameter int unsigned ROW  = 16,
    parameter int unsigned GRP  = 4,
    parameter int unsigned ADIG = 4,
    parameter logic [7:0]  DOT  = 8'h2e
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ASZ-1:0] addr,
    input  logic [ASZ-1:0] len,
    input  logic           ascii_en,
    output logic           mem_rd,
    output logic [ASZ-1:0] mem_addr,
    input  logic [7:0]     mem_data,
    output logic           out_valid,
    output logic [7:0]     out_data,
    input  logic           out_ready,
    output logic           busy,
    output logic           done
);

    localparam int unsigned LROW = $clog2(ROW);
    localparam int unsigned RW   = ASZ - LROW + 1;
    localparam int unsigned AW   = ADIG * 4;
    localparam int unsigned DW   = (ADIG > 1) ? $clog2(ADIG) : 1;

    localparam logic [7:0] CH_NL    = 8'h0a;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3a;

    typedef enum logic [3:0] {
        S_IDLE,
        S_NL,
        S_ADR,
        S_COLON,
        S_HSP,
        S_HRD,
        S_HWT,
        S_HHI,
        S_HLO,
        S_ASP,
        S_ARD,
        S_AWT,
        S_ACH,
        S_FIN
    } state_t;

    state_t         state;
    logic [ASZ-1:0] row_addr;
    logic [RW-1:0]  rows_left;
    logic [LROW-1:0] idx;
    logic [DW-1:0]  dig;
    logic           sp_cnt;
    logic           ascii_q;
    logic [7:0]     byte_q;

    logic           accept;
    logic [ASZ-1:0] row_mask;
    logic [ASZ-1:0] start_last;
    logic [ASZ-1:0] start_row0;
    logic [ASZ-1:0] row_span;
    logic [RW-1:0]  start_nrows;
    logic [AW-1:0]  adr_pad;
    logic [DW-1:0]  dig_nxt;
    logic [3:0]     adr_nib_first;
    logic [3:0]     adr_nib_next;
    logic [LROW-1:0] idx_nxt;
    logic           idx_last;
    logic           grp_edge;
    logic           last_row;

    // Lowercase hex digit for a nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Printable byte or the substitute character.
    function automatic logic [7:0] asc_char(input logic [7:0] b);
        asc_char = ((b < 8'h20) || (b > 8'h7e)) ? DOT : b;
    endfunction

    // Range setup, address digit selection and per-row index bookkeeping.
    always_comb begin
        accept        = out_valid & out_ready;
        row_mask      = ~ASZ'(ROW - 1);
        start_last    = addr + len - ASZ'(1);
        start_row0    = addr & row_mask;
        row_span      = (start_last & row_mask) - start_row0;
        start_nrows   = RW'(row_span >> LROW) + RW'(1);
        adr_pad       = AW'(row_addr);
        dig_nxt       = dig - DW'(1);
        adr_nib_first = 4'(adr_pad >> (4 * (ADIG - 1)));
        adr_nib_next  = 4'(adr_pad >> {dig_nxt, 2'b00});
        idx_nxt       = idx + LROW'(1);
        idx_last      = (idx == LROW'(ROW - 1));
        grp_edge      = ((idx_nxt & LROW'(GRP - 1)) == '0);
        last_row      = (rows_left == RW'(1));
    end

    // Dump sequencer; every output is loaded on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            row_addr  <= '0;
            rows_left <= '0;
            idx       <= '0;
            dig       <= '0;
            sp_cnt    <= 1'b0;
            ascii_q   <= 1'b0;
            byte_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is deliberately dropped.
                    if (start && !done) begin
                        busy      <= 1'b1;
                        ascii_q   <= ascii_en;
                        row_addr  <= start_row0;
                        rows_left <= start_nrows;
                        out_valid <= 1'b1;
                        out_data  <= CH_NL;
                        state     <= (len == '0) ? S_FIN : S_NL;
                    end
                end
                S_NL: begin
                    if (accept) begin
                        state    <= S_ADR;
                        dig      <= DW'(ADIG - 1);
                        out_data <= hex_char(adr_nib_first);
                    end
                end
                S_ADR: begin
                    if (accept) begin
                        if (dig == '0) begin
                            state    <= S_COLON;
                            out_data <= CH_COLON;
                        end else begin
                            dig      <= dig_nxt;
                            out_data <= hex_char(adr_nib_next);
                        end
                    end
                end
                S_COLON: begin
                    if (accept) begin
                        state    <= S_HSP;
                        idx      <= '0;
                        out_data <= CH_SP;
                    end
                end
                S_HSP: begin
                    if (accept) begin
                        state     <= S_HRD;
                        out_valid <= 1'b0;
                        mem_rd    <= 1'b1;
                        mem_addr  <= row_addr + ASZ'(idx);
                    end
                end
                S_HRD: begin
                    state  <= S_HWT;
                    mem_rd <= 1'b0;
                end
                S_HWT: begin
                    state     <= S_HHI;
                    byte_q    <= mem_data;
                    out_valid <= 1'b1;
                    out_data  <= hex_char(mem_data[7:4]);
                end
                S_HHI: begin
                    if (accept) begin
                        state    <= S_HLO;
                        out_data <= hex_char(byte_q[3:0]);
                    end
                end
                S_HLO: begin
                    if (accept) begin
                        if (!idx_last) begin
                            idx <= idx_nxt;
                            if (grp_edge) begin
                                state    <= S_HSP;
                                out_data <= CH_SP;
                            end else begin
                                state     <= S_HRD;
                                out_valid <= 1'b0;
                                mem_rd    <= 1'b1;
                                mem_addr  <= row_addr + ASZ'(idx_nxt);
                            end
                        end else if (ascii_q) begin
                            state    <= S_ASP;
                            sp_cnt   <= 1'b0;
                            out_data <= CH_SP;
                        end else if (last_row) begin
                            state    <= S_FIN;
                            out_data <= CH_NL;
                        end else begin
                            state     <= S_NL;
                            row_addr  <= row_addr + ASZ'(ROW);
                            rows_left <= rows_left - RW'(1);
                            out_data  <= CH_NL;
                        end
                    end
                end
                S_ASP: begin
                    if (accept) begin
                        if (!sp_cnt) begin
                            sp_cnt <= 1'b1;
                        end else begin
                            state     <= S_ARD;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            mem_rd    <= 1'b1;
                            mem_addr  <= row_addr;
                        end
                    end
                end
                S_ARD: begin
                    state  <= S_AWT;
                    mem_rd <= 1'b0;
                end
                S_AWT: begin
                    state     <= S_ACH;
                    out_valid <= 1'b1;
                    out_data  <= asc_char(mem_data);
                end
                S_ACH: begin
                    if (accept) begin
                        if (!idx_last) begin
                            state     <= S_ARD;
                            idx       <= idx_nxt;
                            out_valid <= 1'b0;
                            mem_rd    <= 1'b1;
                            mem_addr  <= row_addr + ASZ'(idx_nxt);
                        end else if (last_row) begin
                            state    <= S_FIN;
                            out_data <= CH_NL;
                        end else begin
                            state     <= S_NL;
                            row_addr  <= row_addr + ASZ'(ROW);
                            rows_left <= rows_left - RW'(1);
                            out_data  <= CH_NL;
                        end
                    end
                end
                S_FIN: begin
                    if (accept) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_engine.sv
// Self-checking bench for mem_dump_engine: directed and randomized dumps
// compared against a string-formatting reference model.
module tb_mem_dump_engine;

    localparam int unsigned ASZ = 17;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [ASZ-1:0] addr;
    logic [ASZ-1:0] len;
    logic           ascii_en;
    logic           mem_rd;
    logic [ASZ-1:0] mem_addr;
    logic [7:0]     mem_data = 8'h00;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_ready;
    logic           busy;
    logic           done;

    logic [7:0]     mem [0:(1<<ASZ)-1];
    logic [7:0]     got_q[$];
    logic [ASZ-1:0] rd_q[$];
    logic [7:0]     exp_q[$];
    logic [ASZ-1:0] exprd_q[$];

    int   done_cnt  = 0;
    int   stab_err  = 0;
    logic hold_q    = 1'b0;
    logic [7:0] hold_data = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int last_gbase;
    int last_rbase;

    mem_dump_engine #(
        .ASZ (17),
        .ROW (16),
        .GRP (4),
        .ADIG(4),
        .DOT (8'h2e)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr     (addr),
        .len      (len),
        .ascii_en (ascii_en),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    // Observe handshakes, reads, done pulses and hold stability mid-cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (mem_rd) rd_q.push_back(mem_addr);
        if (done) done_cnt <= done_cnt + 1;
        if (hold_q && (!out_valid || out_data !== hold_data)) stab_err <= stab_err + 1;
        hold_q    <= out_valid && !out_ready;
        hold_data <= out_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rnd_ready(input int duty);
        return ($urandom_range(99) < duty);
    endfunction

    task automatic push_str(input string s);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(8'(s[k]));
    endtask

    // Reference: format the dump text directly from the row/group rules.
    task automatic build_model(input logic [16:0] a, input logic [16:0] l, input bit asc);
        logic [16:0] row0, last, span, ra, ba;
        logic [7:0]  b;
        int          nrows;
        exp_q.delete();
        exprd_q.delete();
        if (l == 17'd0) begin
            exp_q.push_back(8'h0a);
            return;
        end
        row0  = a & 17'h1fff0;
        last  = (a + l - 17'd1) & 17'h1fff0;
        span  = last - row0;
        nrows = int'(span / 17'd16) + 1;
        for (int r = 0; r < nrows; r++) begin
            ra = row0 + 17'(r * 16);
            push_str($sformatf("\n%04x:", ra[15:0]));
            for (int i = 0; i < 16; i++) begin
                ba = ra + 17'(i);
                if (i % 4 == 0) push_str(" ");
                push_str($sformatf("%02x", mem[ba]));
                exprd_q.push_back(ba);
            end
            if (asc) begin
                push_str("  ");
                for (int i = 0; i < 16; i++) begin
                    ba = ra + 17'(i);
                    b  = mem[ba];
                    exp_q.push_back(((b < 8'h20) || (b > 8'h7e)) ? 8'h2e : b);
                    exprd_q.push_back(ba);
                end
            end
        end
        exp_q.push_back(8'h0a);
    endtask

    task automatic cmp_out(input string tag, input int gbase);
        int mm;
        int first;
        mm    = 0;
        first = -1;
        check({tag, "_nchars"}, 32'(got_q.size() - gbase), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (gbase + i >= got_q.size() || got_q[gbase + i] !== exp_q[i]) begin
                mm++;
                if (first < 0) first = i;
            end
        end
        check({tag, "_char_mismatches"}, 32'(mm), 32'd0);
        if (first >= 0 && gbase + first < got_q.size())
            check($sformatf("%s_char%0d", tag, first), 32'(got_q[gbase + first]), 32'(exp_q[first]));
    endtask

    task automatic cmp_rd(input string tag, input int rbase);
        int mm;
        mm = 0;
        check({tag, "_nreads"}, 32'(rd_q.size() - rbase), 32'(exprd_q.size()));
        for (int i = 0; i < exprd_q.size(); i++) begin
            if (rbase + i >= rd_q.size() || rd_q[rbase + i] !== exprd_q[i]) mm++;
        end
        check({tag, "_read_addr_mismatches"}, 32'(mm), 32'd0);
    endtask

    // One dump: start it, run the sink at the given ready duty, then check everything.
    task automatic run_dump(input string tag, input logic [16:0] a, input logic [16:0] l,
                            input bit asc, input int duty, input int rst_at);
        int gbase, rbase, dbase, sbase, cyc, busy_cyc, busy_gap;
        bit fin, busy_at_done;
        build_model(a, l, asc);
        gbase = got_q.size();
        rbase = rd_q.size();
        dbase = done_cnt;
        sbase = stab_err;
        last_gbase = gbase;
        last_rbase = rbase;
        @(posedge clk); #1;
        addr = a; len = l; ascii_en = asc; start = 1'b1;
        out_ready = rnd_ready(duty);
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = rnd_ready(duty);
        fin = 1'b0; busy_at_done = 1'b0; cyc = 0; busy_cyc = 0; busy_gap = 0;
        while (!fin && cyc < 20000) begin
            @(negedge clk); #1;
            cyc++;
            if (done) begin
                fin = 1'b1;
                busy_at_done = busy;
            end else if (busy) begin
                busy_cyc++;
            end else begin
                busy_gap++;
            end
            if (!fin && rst_at >= 0 && (got_q.size() - gbase) >= rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk); #1;
                check({tag, "_rst_out_valid"}, 32'(out_valid), 32'd0);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_mem_rd"}, 32'(mem_rd), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                gbase = got_q.size();
                rbase = rd_q.size();
                repeat (6) @(negedge clk);
                #1;
                check({tag, "_rst_no_done"}, 32'(done_cnt - dbase), 32'd0);
                check({tag, "_rst_no_chars"}, 32'(got_q.size() - gbase), 32'd0);
                check({tag, "_rst_no_reads"}, 32'(rd_q.size() - rbase), 32'd0);
                return;
            end
            if (!fin) begin
                @(posedge clk); #1;
                out_ready = rnd_ready(duty);
                if (duty < 100) start = ($urandom_range(7) == 0);
            end
        end
        check({tag, "_finished"}, 32'(fin), 32'd1);
        check({tag, "_busy_low_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, "_busy_gaps"}, 32'(busy_gap), 32'd0);
        // Start raised while done is high must be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        check({tag, "_start_on_done_ignored"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_done_pulses"}, 32'(done_cnt - dbase), 32'd1);
        check({tag, "_hold_stable"}, 32'(stab_err - sbase), 32'd0);
        cmp_out(tag, gbase);
        cmp_rd(tag, rbase);
        if (duty >= 100)
            check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_q.size() + 2 * exprd_q.size()));
    endtask

    initial begin
        string row0_txt;
        string z4;
        int    mm;
        rst = 1'b1; start = 1'b0; addr = '0; len = '0; ascii_en = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_mem_rd", 32'(mem_rd), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two rows with ASCII column, sink always ready.
        run_dump("t1", 17'h01003, 17'h00010, 1'b1, 100, -1);
        check("t1_total_chars", 32'(got_q.size() - last_gbase), 32'd121);
        row0_txt = "\n1000: 00010203 04050607 08090a0b 0c0d0e0f  ";
        mm = 0;
        for (int i = 0; i < 60; i++) begin
            if (last_gbase + i >= got_q.size()) mm++;
            else if (i < 44 && got_q[last_gbase + i] !== 8'(row0_txt[i])) mm++;
            else if (i >= 44 && got_q[last_gbase + i] !== 8'h2e) mm++;
        end
        check("t1_row0_text", 32'(mm), 32'd0);

        // Hex only: no ASCII reads.
        run_dump("t2", 17'h01003, 17'h00010, 1'b0, 100, -1);
        check("t2_total_chars", 32'(got_q.size() - last_gbase), 32'd85);
        check("t2_total_reads", 32'(rd_q.size() - last_rbase), 32'd32);

        // Empty range.
        run_dump("t3", 17'h01003, 17'h00000, 1'b1, 100, -1);
        check("t3_total_chars", 32'(got_q.size() - last_gbase), 32'd1);
        check("t3_newline", (got_q.size() > last_gbase) ? 32'(got_q[last_gbase]) : 32'hffff_ffff, 32'h0a);
        check("t3_no_reads", 32'(rd_q.size() - last_rbase), 32'd0);

        // Back-pressured sink, 30% ready.
        run_dump("t4", 17'h01003, 17'h00010, 1'b1, 30, -1);

        // Range crossing the top of memory.
        run_dump("t5", 17'h1fff8, 17'h00010, 1'b1, 100, -1);
        check("t5_wrap_read_addr",
              (rd_q.size() > last_rbase + 32) ? 32'(rd_q[last_rbase + 32]) : 32'hffff_ffff, 32'd0);
        z4 = "0000";
        mm = 0;
        for (int i = 0; i < 4; i++) begin
            if (last_gbase + 61 + i >= got_q.size() || got_q[last_gbase + 61 + i] !== 8'(z4[i])) mm++;
        end
        check("t5_wrap_row_label", 32'(mm), 32'd0);

        // Reset during the second row's hex pass, then a clean rerun.
        run_dump("t6", 17'h01003, 17'h00010, 1'b1, 100, 70);
        run_dump("t6b", 17'h01003, 17'h00010, 1'b1, 100, -1);
        check("t6b_total_chars", 32'(got_q.size() - last_gbase), 32'd121);

        // Randomized contents, ranges, modes and sink duty.
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 6; t++) begin
            run_dump($sformatf("rnd%0d", t), 17'($urandom), 17'($urandom_range(80)),
                     1'($urandom_range(1)), (t % 2 == 0) ? 100 : int'($urandom_range(20, 90)), -1);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
